// File: rtl/binarize_pkg.sv
// Shared constants for the RGB565 binariser: mode encoding, gray weights, mask levels,
// and the shift-add gray sum used by the datapath.
package binarize_pkg;

  localparam logic [2:0] MODE_RED      = 3'd0;
  localparam logic [2:0] MODE_GREEN    = 3'd1;
  localparam logic [2:0] MODE_BLUE     = 3'd2;
  localparam logic [2:0] MODE_GRAY_RAW = 3'd3;
  localparam logic [2:0] MODE_GRAY_BIN = 3'd4;

  localparam int unsigned COEF_R = 77;
  localparam int unsigned COEF_G = 150;
  localparam int unsigned COEF_B = 29;

  localparam logic [7:0] MASK_OFF = 8'h00;
  localparam logic [7:0] MASK_ON  = 8'hFF;

  // 77 = 64+8+4+1, 150 = 128+16+4+2, 29 = 16+8+4+1
  function automatic logic [16:0] gray_sum(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [16:0] rr, gg, bb;
    rr = {9'd0, r};
    gg = {9'd0, g};
    bb = {9'd0, b};
    return (rr << 6) + (rr << 3) + (rr << 2) + rr
         + (gg << 7) + (gg << 4) + (gg << 2) + (gg << 1)
         + (bb << 4) + (bb << 3) + (bb << 2) + bb;
  endfunction

endpackage

// File: rtl/threshold_ctrl.sv
// Pending threshold register driven by rising edges of the debounced plus/sub buttons,
// with bounded stepping that either wraps to the opposite bound or saturates.
module threshold_ctrl #(
  parameter int unsigned TH_INIT = 128,
  parameter int unsigned TH_MIN  = 112,
  parameter int unsigned TH_MAX  = 192,
  parameter int unsigned TH_STEP = 2,
  parameter bit          WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       plus,
  input  logic       sub,
  output logic [7:0] th
);

  localparam logic [8:0] MIN9  = 9'(TH_MIN);
  localparam logic [8:0] MAX9  = 9'(TH_MAX);
  localparam logic [8:0] STEP9 = 9'(TH_STEP);

  logic plus_q, sub_q, plus_edge, sub_edge;
  logic [8:0] up9, dn_lim9;

  assign up9     = {1'b0, th} + STEP9;
  assign dn_lim9 = MIN9 + STEP9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plus_q    <= 1'b0;
      sub_q     <= 1'b0;
      plus_edge <= 1'b0;
      sub_edge  <= 1'b0;
      th        <= 8'(TH_INIT);
    end else begin
      plus_q    <= plus;
      sub_q     <= sub;
      plus_edge <= plus & ~plus_q;
      sub_edge  <= sub & ~sub_q;
      // Coincident edges cancel out.
      if (plus_edge && !sub_edge) begin
        if (up9 > MAX9) th <= WRAP ? MIN9[7:0] : MAX9[7:0];
        else            th <= up9[7:0];
      end else if (sub_edge && !plus_edge) begin
        if ({1'b0, th} < dn_lim9) th <= WRAP ? MAX9[7:0] : MIN9[7:0];
        else                      th <= th - STEP9[7:0];
      end
    end
  end

endmodule

// File: rtl/rgb565_binarize_pipe.sv
// Three-stage RGB565 -> 8-bit mask/gray pipeline with frame-synchronous threshold and mode.
// Stream: in_valid qualifies each pixel, no back-pressure; out_valid/out_sof trail by 3 clocks.
module rgb565_binarize_pipe
  import binarize_pkg::*;
#(
  parameter int unsigned TH_INIT = 128,
  parameter int unsigned TH_MIN  = 112,
  parameter int unsigned TH_MAX  = 192,
  parameter int unsigned TH_STEP = 2,
  parameter bit          WRAP    = 1'b1,
  parameter int unsigned LIM_RB  = 96,
  parameter int unsigned LIM_G   = 112
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [15:0] in_data,
  input  logic [2:0]  mode,
  input  logic        plus,
  input  logic        sub,
  output logic        out_valid,
  output logic        out_sof,
  output logic [7:0]  out_data,
  output logic [7:0]  threshold
);

  localparam logic [7:0] LIM_RB8 = 8'(LIM_RB);
  localparam logic [7:0] LIM_G8  = 8'(LIM_G);

  logic [7:0] th_pend;

  threshold_ctrl #(
    .TH_INIT(TH_INIT), .TH_MIN(TH_MIN), .TH_MAX(TH_MAX), .TH_STEP(TH_STEP), .WRAP(WRAP)
  ) u_threshold_ctrl (
    .clk(clk), .rst_n(rst_n), .plus(plus), .sub(sub), .th(th_pend)
  );

  assign threshold = th_pend;

  // Frame context: the sof pixel itself already uses the freshly latched values.
  logic       sof_acc;
  logic [7:0] act_th, ctx_th;
  logic [2:0] act_mode, ctx_mode;

  assign sof_acc  = in_valid && in_sof;
  assign ctx_th   = sof_acc ? th_pend : act_th;
  assign ctx_mode = sof_acc ? mode : act_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_th   <= 8'(TH_INIT);
      act_mode <= MODE_RED;
    end else if (sof_acc) begin
      act_th   <= th_pend;
      act_mode <= mode;
    end
  end

  // S1: channel expansion and context capture
  logic       s1_valid, s1_sof;
  logic [7:0] s1_r, s1_g, s1_b, s1_th;
  logic [2:0] s1_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_r     <= 8'd0;
      s1_g     <= 8'd0;
      s1_b     <= 8'd0;
      s1_th    <= 8'd0;
      s1_mode  <= MODE_RED;
    end else begin
      s1_valid <= in_valid;
      s1_sof   <= sof_acc;
      s1_r     <= {in_data[15:11], in_data[15:13]};
      s1_g     <= {in_data[10:5], in_data[10:9]};
      s1_b     <= {in_data[4:0], in_data[4:2]};
      s1_th    <= ctx_th;
      s1_mode  <= ctx_mode;
    end
  end

  // S2: compares and gray sum
  logic [16:0] sum;
  logic        col_hit;

  assign sum = gray_sum(s1_r, s1_g, s1_b);

  always_comb begin
    col_hit = 1'b0;
    case (s1_mode)
      MODE_RED:   col_hit = (s1_r >= s1_th) && (s1_g <= LIM_RB8) && (s1_b <= LIM_RB8);
      MODE_GREEN: col_hit = (s1_g >= s1_th) && (s1_r <= LIM_G8) && (s1_b <= LIM_G8);
      MODE_BLUE:  col_hit = (s1_b >= s1_th) && (s1_r <= LIM_RB8) && (s1_g <= LIM_RB8);
      default:    col_hit = 1'b0;
    endcase
  end

  logic       s2_valid, s2_sof, s2_hit, s2_gray_ge;
  logic [7:0] s2_gray;
  logic [2:0] s2_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_sof     <= 1'b0;
      s2_hit     <= 1'b0;
      s2_gray_ge <= 1'b0;
      s2_gray    <= 8'd0;
      s2_mode    <= MODE_RED;
    end else begin
      s2_valid   <= s1_valid;
      s2_sof     <= s1_sof;
      s2_hit     <= col_hit;
      s2_gray_ge <= sum[16] || (sum[15:8] >= s1_th);
      s2_gray    <= sum[15:8];
      s2_mode    <= s1_mode;
    end
  end

  // S3: output select; data holds while no pixel is presented
  logic [7:0] sel;

  always_comb begin
    sel = MASK_ON;
    case (s2_mode)
      MODE_RED, MODE_GREEN, MODE_BLUE: sel = s2_hit ? MASK_OFF : MASK_ON;
      MODE_GRAY_RAW:                   sel = s2_gray;
      MODE_GRAY_BIN:                   sel = s2_gray_ge ? MASK_ON : MASK_OFF;
      default:                         sel = MASK_ON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= MASK_OFF;
    end else begin
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      if (s2_valid) out_data <= sel;
    end
  end

endmodule

// File: tb/tb_rgb565_binarize_pipe.sv
// Directed bench for rgb565_binarize_pipe: pixel results, frame-synchronous context,
// threshold stepping with wrap and saturate variants, stream alignment and reset.
module tb_rgb565_binarize_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof, plus, sub;
  logic [15:0] in_data;
  logic [2:0]  mode;
  logic        out_valid, out_sof;
  logic [7:0]  out_data, threshold;
  logic        sat_valid, sat_sof;
  logic [7:0]  sat_data, sat_th;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  rgb565_binarize_pipe #(.WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .plus(plus), .sub(sub), .out_valid(out_valid), .out_sof(out_sof),
    .out_data(out_data), .threshold(threshold)
  );

  rgb565_binarize_pipe #(.WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .plus(plus), .sub(sub), .out_valid(sat_valid), .out_sof(sat_sof),
    .out_data(sat_data), .threshold(sat_th)
  );

  // clock / reference delay line for valid and sof
  always #5 clk = ~clk;

  logic mv1, mv2, mv3, ms1, ms2, ms3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {mv1, mv2, mv3} <= 3'b000;
      {ms1, ms2, ms3} <= 3'b000;
    end else begin
      mv1 <= in_valid;          mv2 <= mv1; mv3 <= mv2;
      ms1 <= in_valid && in_sof; ms2 <= ms1; ms3 <= ms2;
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (out_valid === mv3 && out_sof === ms3) else begin
        errors++;
        $error("FAIL align got=%b%b exp=%b%b", out_valid, out_sof, mv3, ms3);
      end
      if (out_valid === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pixel got=%b_%h exp=none", out_sof, out_data);
        end
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          checks++;
          assert ({out_sof, out_data} === e) else begin
            errors++;
            $error("FAIL pixel got=%b_%h exp=%b_%h", out_sof, out_data, e[8], e[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic [7:0] e);
    in_valid = 1'b1;
    in_sof   = s;
    in_data  = d;
    exp_q.push_back({s, e});
    tick(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    tick(5);
    chk("drain_empty", 9'(exp_q.size()), 9'd0);
  endtask

  task automatic press_plus();
    plus = 1'b1;
    tick(3);
    plus = 1'b0;
    tick(2);
  endtask

  task automatic press_sub();
    sub = 1'b1;
    tick(3);
    sub = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 16'h0000;
    mode     = 3'd0;
    plus     = 1'b0;
    sub      = 1'b0;
    tick(2);
    chk("rst_out_valid", 9'(out_valid), 9'd0);
    chk("rst_out_sof", 9'(out_sof), 9'd0);
    chk("rst_out_data", 9'(out_data), 9'h00);
    chk("rst_threshold", 9'(threshold), 9'd128);
    rst_n = 1'b1;
    tick(1);

    // pixel before any sof uses reset context (red, th 128), not the mode port
    mode = 3'd3;
    send(16'hF800, 1'b0, 8'h00);
    drain();

    // red mode, th 128
    mode = 3'd0;
    send(16'hF800, 1'b1, 8'h00);
    send(16'h7800, 1'b0, 8'hFF);
    send(16'hFFE0, 1'b0, 8'hFF);
    drain();
    chk("hold_out_data", 9'(out_data), 9'hFF);

    // green / blue modes
    mode = 3'd1;
    send(16'h07E0, 1'b1, 8'h00);
    send(16'hF7E0, 1'b0, 8'hFF);
    mode = 3'd2;
    send(16'h001F, 1'b1, 8'h00);
    send(16'h07FF, 1'b0, 8'hFF);
    drain();

    // gray raw, gray binary, reserved
    mode = 3'd3;
    send(16'h8410, 1'b1, 8'h82);
    send(16'hFFFF, 1'b0, 8'hFF);
    send(16'h0000, 1'b0, 8'h00);
    mode = 3'd4;
    send(16'h8410, 1'b1, 8'hFF);
    send(16'h7800, 1'b0, 8'h00);
    mode = 3'd5;
    send(16'h0000, 1'b1, 8'hFF);
    drain();

    // held button is one press; simultaneous edges cancel
    plus = 1'b1;
    tick(2);
    chk("th_two_clocks", 9'(threshold), 9'd130);
    tick(98);
    plus = 1'b0;
    tick(2);
    chk("th_held_plus", 9'(threshold), 9'd130);
    plus = 1'b1;
    sub  = 1'b1;
    tick(4);
    plus = 1'b0;
    sub  = 1'b0;
    tick(2);
    chk("th_both_edges", 9'(threshold), 9'd130);
    press_sub();
    chk("th_sub", 9'(threshold), 9'd128);

    // upper bound: wrap vs saturate
    for (int i = 0; i < 32; i++) press_plus();
    chk("th_wrap_at_max", 9'(threshold), 9'd192);
    chk("th_sat_at_max", 9'(sat_th), 9'd192);
    press_plus();
    chk("th_wrap_over_max", 9'(threshold), 9'd112);
    chk("th_sat_over_max", 9'(sat_th), 9'd192);

    // lower bound: wrap vs saturate
    do_reset();
    for (int i = 0; i < 8; i++) press_sub();
    chk("th_wrap_at_min", 9'(threshold), 9'd112);
    chk("th_sat_at_min", 9'(sat_th), 9'd112);
    press_sub();
    chk("th_wrap_under_min", 9'(threshold), 9'd192);
    chk("th_sat_under_min", 9'(sat_th), 9'd112);

    // mid-frame threshold change only takes effect at the next sof (r = 132)
    do_reset();
    mode = 3'd0;
    send(16'h8000, 1'b1, 8'h00);
    press_plus();
    press_plus();
    press_plus();
    chk("th_pending_mid", 9'(threshold), 9'd134);
    send(16'h8000, 1'b0, 8'h00);
    send(16'h8000, 1'b1, 8'hFF);
    drain();

    // continuous stream in gray raw with random gaps, then reset in flight
    mode = 3'd3;
    for (int i = 0; i < 24; i++) begin
      logic v;
      v = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_valid = v;
      in_sof   = (i == 0);
      in_data  = i[0] ? 16'hFFFF : 16'h0000;
      if (v) exp_q.push_back({(i == 0), (i[0] ? 8'hFF : 8'h00)});
      tick(1);
    end
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_data  = 16'hFFFF;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 9'(out_valid), 9'd0);
    chk("mid_rst_threshold", 9'(threshold), 9'd128);
    exp_q.delete();
    in_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_out_valid", 9'(out_valid), 9'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
